// File: rtl/fsm_cmd_arbiter.sv
// Round-robin arbiter that time-shares the command input of one FSM among NUM_REQ requesters.
// One command is in flight at a time: hold on fsm_in, settle, sample fsm_out, return it.
module fsm_cmd_arbiter #(
    parameter int                   NUM_REQ       = 4,
    parameter int                   CMD_WIDTH     = 2,
    parameter int                   OUT_WIDTH     = 2,
    parameter logic [CMD_WIDTH-1:0] IDLE_CMD      = 2'h3,
    parameter int                   HOLD_CYCLES   = 1,
    parameter int                   SETTLE_CYCLES = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*CMD_WIDTH-1:0] req_cmd,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [CMD_WIDTH-1:0]         fsm_in,
    input  logic [OUT_WIDTH-1:0]         fsm_out,
    output logic                         rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
    output logic [OUT_WIDTH-1:0]         rsp_data,
    input  logic                         rsp_ready,
    output logic                         busy
);

    localparam int ID_W    = $clog2(NUM_REQ);
    localparam int CNT_MAX = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [ID_W:0]    NUM_REQ_W   = (ID_W + 1)'(NUM_REQ);
    localparam logic [ID_W-1:0]  LAST_ID     = ID_W'(NUM_REQ - 1);

    // Handshakes: a transfer happens in a cycle where valid and ready are both high.
    // req_ready is only ever raised in IDLE; rsp_valid holds with stable id/data until rsp_ready.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        SETTLE = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  rr_ptr_nxt;
    logic [ID_W-1:0]  win_id;
    logic [ID_W:0]    scan_idx;
    logic             win_found;
    logic             accept;
    logic             hold_done;
    logic             capture;

    // Scan upward from rr_ptr, wrapping modulo NUM_REQ; first valid requester wins.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, rr_ptr} + (ID_W + 1)'(k);
            if (scan_idx >= NUM_REQ_W) begin
                scan_idx = scan_idx - NUM_REQ_W;
            end
            if (!win_found && req_valid[scan_idx[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_id    = scan_idx[ID_W-1:0];
            end
        end
    end

    assign accept     = (state == IDLE) && win_found;
    assign rr_ptr_nxt = (win_id == LAST_ID) ? '0 : win_id + ID_W'(1);

    always_comb begin
        req_ready = '0;
        if (accept && rst_n) begin
            req_ready[win_id] = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        hold_done = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_nxt = ISSUE;
                    cnt_nxt   = HOLD_LOAD;
                end
            end
            ISSUE: begin
                if (cnt == '0) begin
                    state_nxt = SETTLE;
                    cnt_nxt   = SETTLE_LOAD;
                    hold_done = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            SETTLE: begin
                if (cnt == '0) begin
                    state_nxt = RESP;
                    capture   = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // fsm_in doubles as the command latch: loaded on accept, parked at IDLE_CMD after the hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            fsm_in   <= IDLE_CMD;
            rsp_id   <= '0;
            rsp_data <= '0;
        end else begin
            if (accept) begin
                fsm_in <= req_cmd[win_id*CMD_WIDTH +: CMD_WIDTH];
                rsp_id <= win_id;
                rr_ptr <= rr_ptr_nxt;
            end
            if (hold_done) begin
                fsm_in <= IDLE_CMD;
            end
            if (capture) begin
                rsp_data <= fsm_out;
            end
        end
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

endmodule

// File: doc/fsm_cmd_arbiter.md
# fsm_cmd_arbiter

Round-robin scheduler that shares the 2-bit command input of a single state-machine block (e.g. the Color FSM) between `NUM_REQ` requesters. It accepts one command at a time over a valid/ready handshake and drives it onto the FSM input for a fixed hold window. After a settle window it samples the FSM output and returns it to the winning requester over a second valid/ready handshake. It sits between the requester fabric and the FSM, so that only one owner drives the FSM at a time.

## Interface
- `NUM_REQ`, default 4: number of requesters, ≥2.
- `CMD_WIDTH`, default 2: command width; matches the FSM `in` port.
- `OUT_WIDTH`, default 2: FSM output width.
- `IDLE_CMD`, default 2'h3: value driven on `fsm_in` when no command is active; it must not cause any FSM transition.
- `HOLD_CYCLES`, default 1: cycles each command is held on `fsm_in`, ≥1.
- `SETTLE_CYCLES`, default 1: cycles between hold end and output sample, ≥1.

Ports:
- `clk`  in  1  the single clock; all logic is rising-edge.
- `rst_n`  in  1  asynchronous reset, active-low.
- `req_valid`  in  NUM_REQ  per-requester command valid.
- `req_cmd`  in  NUM_REQ*CMD_WIDTH  per-requester command; requester i uses slice [i*CMD_WIDTH +: CMD_WIDTH].
- `req_ready`  out  NUM_REQ  one-hot accept strobe.
- `fsm_in`  out  CMD_WIDTH  registered command to the FSM.
- `fsm_out`  in  OUT_WIDTH  FSM output.
- `rsp_valid`  out  1  response valid.
- `rsp_id`  out  $clog2(NUM_REQ)  index of the requester that owns the response.
- `rsp_data`  out  OUT_WIDTH  sampled FSM output.
- `rsp_ready`  in  1  response accept.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States are IDLE, ISSUE, SETTLE and RESP. The state register, counter, pointer and response fields are registered.
- **IDLE**
  - `req_ready[w]` is driven combinationally high for the winner w: the first i with `req_valid[i]`=1, scanning upward from `rr_ptr` and wrapping modulo NUM_REQ.
  - With no valid request, `req_ready` is all zeros.
  - On acceptance: latch `req_cmd[w]` and `rsp_id`=w, set `rr_ptr` = (w+1) mod NUM_REQ, load counter=HOLD_CYCLES-1, and go to ISSUE.
- **ISSUE**
  - `fsm_in` = latched cmd.
  - Decrement the counter; when it reaches 0, load counter=SETTLE_CYCLES-1 and go to SETTLE.
- **SETTLE**
  - `fsm_in` = IDLE_CMD.
  - Decrement the counter; when it reaches 0, capture `fsm_out` into `rsp_data` and go to RESP.
- **RESP**
  - `rsp_valid`=1; `rsp_id` and `rsp_data` are stable.
  - If `rsp_ready`=1, go to IDLE.
  - `req_ready` stays 0 throughout ISSUE, SETTLE and RESP.
- **Requester behaviour**
  - A requester may drop `req_valid` at any time before its handshake; this has no effect.
  - After acceptance, the requester's `req_cmd` may change freely.
- **Reset values** (`rst_n` low, asynchronous):
  - state=IDLE, `fsm_in`=IDLE_CMD, `rr_ptr`=0, counter=0.
  - `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `busy`=0, `req_ready`=0.
- **Reset mid-operation**: any in-flight command is abandoned and no response is produced.
- **Counter widths**: $clog2(max(HOLD_CYCLES, SETTLE_CYCLES)+1). All index arithmetic is modulo NUM_REQ; `rr_ptr` wraps from NUM_REQ-1 to 0.

## Timing
- Handshake cycle A (`req_valid` & `req_ready`): the command is latched at the end of A, and `busy` rises at A+1.
- `fsm_in` carries the command during cycles A+1 … A+HOLD_CYCLES, and returns to IDLE_CMD at A+HOLD_CYCLES+1.
- `fsm_out` is sampled at the end of cycle A+HOLD_CYCLES+SETTLE_CYCLES. `rsp_valid` rises at A+HOLD_CYCLES+SETTLE_CYCLES+1; with defaults, that is A+3.
- Response accepted in cycle R (`rsp_valid` & `rsp_ready`): IDLE at R+1, and the next acceptance is possible at R+1. The minimum spacing between acceptances is therefore HOLD+SETTLE+2 cycles.
- With `rsp_ready` held low, RESP persists indefinitely. Outputs stay stable and no new request is accepted.
- Simultaneous requests are resolved by round-robin only; there is no fixed priority beyond the `rr_ptr` scan order.

## Test plan
- **Reset**: assert `rst_n`=0 mid-ISSUE → `fsm_in`=2'h3, `busy`=0 and `rsp_valid`=0 immediately (asynchronously); after release, no response appears.
- **Single request**: requester 2 sends cmd 2'h1 with the FSM in Red → `req_ready`=4'b0100 in cycle A; `fsm_in`=2'h1 at A+1; `fsm_in`=2'h3 at A+2; `rsp_valid` at A+3 with `rsp_id`=2 and `rsp_data`=2'h1 (Blue).
- **Round-robin fairness**: all four requesters hold valid continuously with `rsp_ready`=1 → grant order 0,1,2,3,0; consecutive acceptances are exactly 4 cycles apart.
- **Back-pressure**: `rsp_ready`=0 for 10 cycles → `rsp_valid`, `rsp_id` and `rsp_data` are held; `req_ready`=0 throughout; IDLE is entered the cycle after `rsp_ready`=1.
- **Parameters**: HOLD_CYCLES=3, SETTLE_CYCLES=2 → `fsm_in`=cmd for exactly 3 cycles, and `rsp_valid` at A+6.
- **Withdrawal and wrap**: requester 3 drops valid in IDLE before being granted → no grant to 3. Then a grant to 3 sets `rr_ptr`=0, and a simultaneous request from 0 and 1 grants 0.
